store_buffer: RTL

//  Posted-write buffer between the pipelined cpu's MEM-stage load/store ports and the external data memory.

---
 rtl/store_buffer_pkg.sv | 13 +
 rtl/store_buffer_if.sv | 33 +++
 rtl/store_buffer_fifo.sv | 64 ++++++
 rtl/store_buffer.sv | 104 ++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared widths, depth default and FSM state type for the posted-write store buffer.
package store_buffer_pkg;

  localparam int SB_W     = 32;
  localparam int SB_DEPTH = 4;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_WRITE = 2'd1,
    SB_READ  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/store_buffer_if.sv
// Req/ack data-memory bus between the store buffer (master) and external memory (slave).
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int W = SB_W
);

  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/store_buffer_fifo.sv
// Store queue: circular storage of {addr,data} entries plus a youngest-match
// lookup so queued stores can be forwarded to loads.
module store_buffer_fifo #(
  parameter int W      = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_addr,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic [W-1:0]     l_addr,
  output logic [W-1:0]     head_addr,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count,
  output logic             hit,
  output logic [W-1:0]     hit_data
);

  logic [W-1:0]     addr_q [DEPTH];
  logic [W-1:0]     data_q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry contents need no reset: count gates every read of them.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
    end
  end

  assign head_addr = addr_q[head];
  assign head_data = data_q[head];

  // Walk from oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (addr_q[head + PTR_W'(i)] == l_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[head + PTR_W'(i)];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues CPU stores, forwards them to loads and
// arbitrates one req/ack memory bus between store drains and load misses.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int W     = SB_W,
  parameter int DEPTH = SB_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           store_en,
  input  logic [W-1:0]   s_addr,
  input  logic [W-1:0]   s_data,
  input  logic           load_en,
  input  logic [W-1:0]   l_addr,
  output logic [W-1:0]   l_data,
  output logic           stall,
  store_buffer_if.master mem
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_state_e        state;
  sb_state_e        next_state;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     head_addr;
  logic [W-1:0]     head_data;
  logic [W-1:0]     hit_data;
  logic             hit;
  logic             full;
  logic             push;
  logic             pop;
  logic             read_done;

  // full decodes the count register only, keeping mem_ack off the store-stall path.
  assign full      = (count == CNT_W'(DEPTH));
  assign push      = store_en && !full;
  assign pop       = (state == SB_WRITE) && mem.mem_ack;
  assign read_done = (state == SB_READ) && mem.mem_ack;

  store_buffer_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (s_addr),
    .push_data (s_data),
    .pop       (pop),
    .l_addr    (l_addr),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SB_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = state;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    stall         = 1'b0;
    l_data        = '0;

    unique case (state)
      SB_IDLE: begin
        if (load_en && !hit)    next_state = SB_READ;
        else if (count != '0)   next_state = SB_WRITE;
      end
      SB_WRITE: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = head_addr;
        mem.mem_wdata = head_data;
        if (mem.mem_ack) next_state = SB_IDLE;
      end
      SB_READ: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = l_addr;
        if (mem.mem_ack) next_state = SB_IDLE;
      end
      default: next_state = SB_IDLE;
    endcase

    // Read data passes straight through on the acking cycle so the load completes without an extra bubble.
    if (load_en) begin
      if (hit)            l_data = hit_data;
      else if (read_done) l_data = mem.mem_rdata;
      else                stall  = 1'b1;
    end else if (store_en && full) begin
      stall = 1'b1;
    end
  end

endmodule
